// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-to-UART drain stage.
// Contents: FSM state encoding (3 bits, StIdle=0 .. StStop=5) and the default bit period.
package uart_pkg;

    // Default number of clk cycles per serial bit.
    localparam int unsigned CLK_DIV = 16;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StFetch = 3'd1,
        StLoad  = 3'd2,
        StStart = 3'd3,
        StData  = 3'd4,
        StStop  = 3'd5
    } uart_state_e;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Bundle between the FIFO read side / serial line and the drain stage.
// Signals: empty (FIFO empty flag), data_in (FIFO data_out, valid the cycle after read),
//          read (FIFO pop strobe), tx (serial line), busy (frame in progress).
// Modports: master = drain stage, slave = FIFO/line side.
interface fifo_uart_tx_if #(
    parameter int unsigned d_w = 8
);
    logic           empty;
    logic [d_w-1:0] data_in;
    logic           read;
    logic           tx;
    logic           busy;

    modport master (
        input  empty,
        input  data_in,
        output read,
        output tx,
        output busy
    );

    modport slave (
        output empty,
        output data_in,
        input  read,
        input  tx,
        input  busy
    );
endinterface

// File: rtl/baud_tick.sv
// Bit-period timer: counts 0..clk_div-1 and wraps.
// Ports: clk (clock), rst (sync active-high reset), clr (restart count at 0),
//        tick (high for one cycle while the count equals clk_div-1).
module baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned clk_div = CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CntW = (clk_div > 1) ? $clog2(clk_div) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(clk_div - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || (cnt_q == CntMax)) begin
            cnt_d = '0;
        end
    end

    assign tick = (cnt_q == CntMax);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drain stage: pops one word from the FIFO whenever it is non-empty in IDLE and
// serialises it as start bit, d_w data bits LSB first, stop bit.
// Ports: clk (clock), rst (sync active-high reset),
//        bus_io (master: empty/data_in in, read/tx/busy out).
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned d_w     = 8,
    parameter int unsigned clk_div = CLK_DIV
) (
    input logic            clk,
    input logic            rst,
    fifo_uart_tx_if.master bus_io
);

    localparam int unsigned IdxW = $clog2(d_w + 1);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(d_w - 1);

    uart_state_e    state_q, state_d;
    logic [d_w-1:0] shift_q, shift_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic           tx_q, tx_d;
    logic           tick;
    logic           tick_clr;
    logic           read_s;
    logic           busy_s;

    assign tick_clr = (state_q == StLoad);

    baud_tick #(
        .clk_div(clk_div)
    ) u_baud_tick (
        .clk (clk),
        .rst (rst),
        .clr (tick_clr),
        .tick(tick)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; empty is only looked at in IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (!bus_io.empty) state_d = StFetch;
            StFetch: state_d = StLoad;
            StLoad:  state_d = StStart;
            StStart: if (tick) state_d = StData;
            StData:  if (tick && (idx_q == LastIdx)) state_d = StStop;
            StStop:  if (tick) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Moore outputs; tx_d is registered so the line lags the state by one cycle
    always_comb begin
        read_s = (state_q == StFetch);
        busy_s = (state_q != StIdle);
        tx_d   = 1'b1;
        unique case (state_q)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_q[0];
            default: tx_d = 1'b1;
        endcase
    end

    // Datapath: capture in LOAD, shift on each data-bit boundary
    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        if (state_q == StLoad) begin
            shift_d = bus_io.data_in;
            idx_d   = '0;
        end else if ((state_q == StData) && tick) begin
            shift_d = {1'b0, shift_q[d_w-1:1]};
            idx_d   = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
        end
    end

    assign bus_io.read = read_s;
    assign bus_io.busy = busy_s;
    assign bus_io.tx   = tx_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a clk_div=4 instance fed by a FIFO model and a clk_div=2 instance
// driven directly. Expected line levels come from the frame format (start, data LSB first,
// stop) and the fixed fetch latency.
module tb_fifo_uart_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fifo_uart_tx_if #(.d_w(8)) bus4 ();
    fifo_uart_tx_if #(.d_w(8)) bus2 ();

    fifo_uart_tx #(.d_w(8), .clk_div(4)) u_dut4 (.clk(clk), .rst(rst), .bus_io(bus4));
    fifo_uart_tx #(.d_w(8), .clk_div(2)) u_dut2 (.clk(clk), .rst(rst), .bus_io(bus2));

    // FIFO model feeding the clk_div=4 instance
    logic [7:0] mem [256];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic [7:0] data4 = 8'h00;
    int         rd4 = 0;
    int         under4 = 0;
    logic       ovr_en = 1'b0;
    logic       ovr_val = 1'b1;

    assign bus4.empty   = ovr_en ? ovr_val : (wr_ptr == rd_ptr);
    assign bus4.data_in = data4;

    always @(posedge clk) begin
        if (rst) begin
            rd_ptr <= wr_ptr;
        end else if (bus4.read) begin
            rd4 <= rd4 + 1;
            if (wr_ptr == rd_ptr) under4 <= under4 + 1;
            else begin
                data4  <= mem[rd_ptr % 256];
                rd_ptr <= rd_ptr + 1;
            end
        end
    end

    // Direct drive of the clk_div=2 instance
    logic       e2 = 1'b1;
    logic [7:0] d2 = 8'h00;
    int         rd2 = 0;

    assign bus2.empty   = e2;
    assign bus2.data_in = d2;

    always @(posedge clk) if (!rst && bus2.read) rd2 <= rd2 + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic tx_of(input int sel);
        return (sel == 1) ? bus2.tx : bus4.tx;
    endfunction

    // Slot 0 is the start bit, slots 1..8 the data LSB first, slot 9 the stop bit
    function automatic logic frame_bit(input logic [7:0] w, input int k);
        if (k == 0) return 1'b0;
        if (k > 8) return 1'b1;
        return w[k-1];
    endfunction

    task automatic push(input logic [7:0] w);
        mem[wr_ptr % 256] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_fall(input int sel, input int budget, output int t);
        bit ok = 1'b0;
        t = -1;
        for (int n = 0; n < budget; n++) begin
            if (tx_of(sel) == 1'b0) begin
                ok = 1'b1;
                t  = cyc;
                break;
            end
            @(negedge clk);
        end
        chk("fall_timeout", {31'd0, ok}, 1);
    endtask

    // Called on the first negedge showing the start bit; checks every cycle of the frame
    task automatic check_frame(input int sel, input logic [7:0] w, input int div,
                               input bit toggle, input string tag);
        for (int i = 0; i < 10 * div; i++) begin
            chk(tag, {31'd0, tx_of(sel)}, {31'd0, frame_bit(w, i / div)});
            if (toggle) begin
                ovr_en  = (i < 9 * div);
                ovr_val = i[0];
            end
            @(negedge clk);
        end
        ovr_en = 1'b0;
        chk({tag, "_idle"}, {31'd0, tx_of(sel)}, 1);
    endtask

    task automatic send_and_check(input logic [7:0] w, input bit toggle, input string tag);
        int base = rd4;
        push(w);
        @(negedge clk);
        chk({tag, "_read_pulse"}, {31'd0, bus4.read}, 1);
        chk({tag, "_tx_e0"}, {31'd0, bus4.tx}, 1);
        @(negedge clk);
        chk({tag, "_read_end"}, {31'd0, bus4.read}, 0);
        chk({tag, "_tx_e1"}, {31'd0, bus4.tx}, 1);
        @(negedge clk);
        chk({tag, "_tx_e2"}, {31'd0, bus4.tx}, 1);
        @(negedge clk);
        chk({tag, "_fall_lat"}, {31'd0, bus4.tx}, 0);
        check_frame(0, w, 4, toggle, tag);
        chk({tag, "_one_read"}, rd4 - base, 1);
    endtask

    initial begin
        int         t;
        int         prev;
        int         base;
        int         t0;
        int         n;
        logic [7:0] w;
        logic [7:0] exp_q[$];

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tx", {31'd0, bus4.tx}, 1);
        chk("rst_read", {31'd0, bus4.read}, 0);
        chk("rst_busy", {31'd0, bus4.busy}, 0);
        chk("rst_tx2", {31'd0, bus2.tx}, 1);
        rst = 1'b0;

        repeat (100) begin
            @(negedge clk);
            chk("idle_tx", {31'd0, bus4.tx}, 1);
            chk("idle_read", {31'd0, bus4.read}, 0);
            chk("idle_busy", {31'd0, bus4.busy}, 0);
        end

        send_and_check(8'hA5, 1'b0, "a5");

        // Burst of 16 words: back-to-back frames 43 cycles apart
        base = rd4;
        for (int i = 1; i <= 16; i++) push(i[7:0]);
        wait_fall(0, 10, t);
        check_frame(0, 8'h01, 4, 1'b0, "burst");
        prev = t;
        for (int i = 2; i <= 16; i++) begin
            wait_fall(0, 20, t);
            chk("burst_period", t - prev, 43);
            check_frame(0, i[7:0], 4, 1'b0, "burst");
            prev = t;
        end
        chk("burst_reads", rd4 - base, 16);
        chk("burst_empty", {31'd0, bus4.empty}, 1);
        chk("burst_underflow", under4, 0);

        // Reset during data bit 3 of 0x3C
        push(8'h3C);
        wait_fall(0, 10, t);
        repeat (17) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_tx", {31'd0, bus4.tx}, 1);
        chk("midrst_busy", {31'd0, bus4.busy}, 0);
        chk("midrst_read", {31'd0, bus4.read}, 0);
        rst  = 1'b0;
        base = rd4;
        repeat (50) begin
            @(negedge clk);
            chk("postrst_tx", {31'd0, bus4.tx}, 1);
        end
        chk("postrst_reads", rd4 - base, 0);

        // Empty toggling mid-frame must not trigger reads
        send_and_check(8'($urandom), 1'b1, "tgl");
        base = rd4;
        repeat (10) begin
            @(negedge clk);
            chk("tgl_quiet", {31'd0, bus4.read}, 0);
        end
        chk("tgl_no_read", rd4 - base, 0);
        send_and_check(8'($urandom), 1'b0, "tgl_next");

        // Random single words with random idle gaps
        repeat (6) begin
            repeat ($urandom_range(0, 15)) begin
                @(negedge clk);
                chk("gap_tx", {31'd0, bus4.tx}, 1);
                chk("gap_read", {31'd0, bus4.read}, 0);
            end
            send_and_check(8'($urandom), 1'b0, "rnd");
        end

        // Random burst checked in order against a queue
        n    = $urandom_range(2, 5);
        base = rd4;
        for (int i = 0; i < n; i++) begin
            w = 8'($urandom);
            exp_q.push_back(w);
            push(w);
        end
        while (exp_q.size() > 0) begin
            wait_fall(0, 20, t);
            check_frame(0, exp_q.pop_front(), 4, 1'b0, "rburst");
        end
        chk("rburst_reads", rd4 - base, n);
        chk("underflow", under4, 0);

        // clk_div = 2 corner: 2-cycle bits, 20-cycle frame
        d2 = 8'($urandom);
        t0 = cyc;
        e2 = 1'b0;
        @(negedge clk);
        chk("cd2_read", {31'd0, bus2.read}, 1);
        e2 = 1'b1;
        wait_fall(1, 10, t);
        chk("cd2_lat", t - t0, 4);
        check_frame(1, d2, 2, 1'b0, "cd2");
        chk("cd2_busy", {31'd0, bus2.busy}, 0);
        chk("cd2_reads", rd2, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
